// File: rtl/cache_ctrl_pkg.sv
// Shared types and default geometry for the cache data-array write scheduler.
package cache_ctrl_pkg;

  localparam int DEF_WORD_SIZE        = 32;
  localparam int DEF_BLOCK_SIZE       = 512;
  localparam int DEF_NUM_SEGMENTS     = 16;
  localparam int DEF_NUM_SEGMENTS_LOG = 4;
  localparam int DEF_INDEX_WIDTH      = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    MERGE = 3'd2,
    FILL  = 3'd3,
    WR    = 3'd4
  } state_t;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_FILL  = 1'b1
  } op_t;

endpackage

// File: rtl/cache_line_write_ctrl_if.sv
// Request, fill and array-port bundle for cache_line_write_ctrl.
// wr_strb exists only when CACHE_WR_STRB_EN is defined.
interface cache_line_write_ctrl_if #(
  parameter int WORD_SIZE        = 32,
  parameter int BLOCK_SIZE       = 512,
  parameter int NUM_SEGMENTS_LOG = 4,
  parameter int INDEX_WIDTH      = 6
);
  logic                        wr_valid;
  logic                        wr_ready;
  logic [INDEX_WIDTH-1:0]      wr_index;
  logic [NUM_SEGMENTS_LOG-1:0] wr_offset;
  logic [WORD_SIZE-1:0]        wr_data;
`ifdef CACHE_WR_STRB_EN
  logic [WORD_SIZE/8-1:0]      wr_strb;
`endif
  logic                        fill_req;
  logic [INDEX_WIDTH-1:0]      fill_index;
  logic                        fill_ack;
  logic                        fill_beat_valid;
  logic                        fill_beat_ready;
  logic [WORD_SIZE-1:0]        fill_beat_data;
  logic                        arr_rd_en;
  logic [INDEX_WIDTH-1:0]      arr_rd_index;
  logic [BLOCK_SIZE-1:0]       arr_rd_data;
  logic                        arr_wr_en;
  logic [INDEX_WIDTH-1:0]      arr_wr_index;
  logic [BLOCK_SIZE-1:0]       arr_wr_data;
  logic                        wr_done;
  logic                        fill_done;
  logic                        busy;

  modport slave (
`ifdef CACHE_WR_STRB_EN
    input  wr_strb,
`endif
    input  wr_valid, wr_index, wr_offset, wr_data,
    input  fill_req, fill_index, fill_beat_valid, fill_beat_data,
    input  arr_rd_data,
    output wr_ready, fill_ack, fill_beat_ready,
    output arr_rd_en, arr_rd_index, arr_wr_en, arr_wr_index, arr_wr_data,
    output wr_done, fill_done, busy
  );

  modport master (
`ifdef CACHE_WR_STRB_EN
    output wr_strb,
`endif
    output wr_valid, wr_index, wr_offset, wr_data,
    output fill_req, fill_index, fill_beat_valid, fill_beat_data,
    output arr_rd_data,
    input  wr_ready, fill_ack, fill_beat_ready,
    input  arr_rd_en, arr_rd_index, arr_wr_en, arr_wr_index, arr_wr_data,
    input  wr_done, fill_done, busy
  );

endinterface

// File: rtl/cache_line_write_ctrl_replacer.sv
// Word-merge datapath: returns line_in with segment seg replaced by word when en is high.
module replacer #(
  parameter int WORD_SIZE        = 32,
  parameter int BLOCK_SIZE       = 512,
  parameter int NUM_SEGMENTS_LOG = 4
) (
  input  logic                        en,
  input  logic [BLOCK_SIZE-1:0]       line_in,
  input  logic [NUM_SEGMENTS_LOG-1:0] seg,
  input  logic [WORD_SIZE-1:0]        word,
  output logic [BLOCK_SIZE-1:0]       line_out
);

  always_comb begin
    line_out = line_in;
    if (en) line_out[int'(seg)*WORD_SIZE +: WORD_SIZE] = word;
  end

endmodule

// File: rtl/cache_line_write_ctrl.sv
// Data-array write-port scheduler: CPU word RMW writes and memory line fills, fills first.
// Byte-strobe merging is enabled by defining CACHE_WR_STRB_EN.
//
// state | meaning
// IDLE  | waiting; fill_req wins over wr_valid
// RD    | array read of captured index
// MERGE | read data valid, merge CPU word into line_buf
// FILL  | collecting fill beats into line_buf
// WR    | write line_buf to array, pulse done
module cache_line_write_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int WORD_SIZE        = DEF_WORD_SIZE,
  parameter int BLOCK_SIZE       = DEF_BLOCK_SIZE,
  parameter int NUM_SEGMENTS     = DEF_NUM_SEGMENTS,
  parameter int NUM_SEGMENTS_LOG = DEF_NUM_SEGMENTS_LOG,
  parameter int INDEX_WIDTH      = DEF_INDEX_WIDTH
) (
  input logic                  clk,
  input logic                  rst,
  cache_line_write_ctrl_if.slave bus
);

  state_t                      state, state_n;
  op_t                         op_q;
  logic [INDEX_WIDTH-1:0]      idx_q;
  logic [NUM_SEGMENTS_LOG-1:0] off_q;
  logic [WORD_SIZE-1:0]        data_q;
`ifdef CACHE_WR_STRB_EN
  logic [WORD_SIZE/8-1:0]      strb_q;
`endif
  logic [NUM_SEGMENTS_LOG-1:0] beat_cnt;
  logic [BLOCK_SIZE-1:0]       line_buf;

  logic [WORD_SIZE-1:0]        merged;
  logic [BLOCK_SIZE-1:0]       rep_line_in;
  logic [NUM_SEGMENTS_LOG-1:0] rep_seg;
  logic [WORD_SIZE-1:0]        rep_word;
  logic [BLOCK_SIZE-1:0]       rep_line_out;
  logic                        last_beat;

  assign last_beat = bus.fill_beat_valid &&
                     (beat_cnt == NUM_SEGMENTS_LOG'(NUM_SEGMENTS - 1));

`ifdef CACHE_WR_STRB_EN
  logic [WORD_SIZE-1:0] rd_word;
  assign rd_word = bus.arr_rd_data[int'(off_q)*WORD_SIZE +: WORD_SIZE];

  always_comb begin
    merged = rd_word;
    for (int b = 0; b < WORD_SIZE/8; b++)
      if (strb_q[b]) merged[b*8 +: 8] = data_q[b*8 +: 8];
  end
`else
  assign merged = data_q;
`endif

  // One replacer serves both the RMW merge and beat insertion.
  always_comb begin
    rep_line_in = bus.arr_rd_data;
    rep_seg     = off_q;
    rep_word    = merged;
    if (state == FILL) begin
      rep_line_in = line_buf;
      rep_seg     = beat_cnt;
      rep_word    = bus.fill_beat_data;
    end
  end

  replacer #(
    .WORD_SIZE       (WORD_SIZE),
    .BLOCK_SIZE      (BLOCK_SIZE),
    .NUM_SEGMENTS_LOG(NUM_SEGMENTS_LOG)
  ) u_replacer (
    .en      (1'b1),
    .line_in (rep_line_in),
    .seg     (rep_seg),
    .word    (rep_word),
    .line_out(rep_line_out)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.fill_req) state_n = FILL;
               else if (bus.wr_valid) state_n = RD;
      RD:      state_n = MERGE;
      MERGE:   state_n = WR;
      FILL:    if (last_beat) state_n = WR;
      WR:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= OP_WRITE;
      idx_q    <= '0;
      off_q    <= '0;
      data_q   <= '0;
`ifdef CACHE_WR_STRB_EN
      strb_q   <= '0;
`endif
      beat_cnt <= '0;
      line_buf <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (bus.fill_req) begin
            op_q     <= OP_FILL;
            idx_q    <= bus.fill_index;
            beat_cnt <= '0;
          end else if (bus.wr_valid) begin
            op_q   <= OP_WRITE;
            idx_q  <= bus.wr_index;
            off_q  <= bus.wr_offset;
            data_q <= bus.wr_data;
`ifdef CACHE_WR_STRB_EN
            strb_q <= bus.wr_strb;
`endif
          end
        end
        MERGE: line_buf <= rep_line_out;
        FILL: begin
          if (bus.fill_beat_valid) begin
            line_buf <= rep_line_out;
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshakes are held low while reset is asserted so every output reads 0 in reset.
  assign bus.wr_ready        = ~rst && (state == IDLE) && ~bus.fill_req;
  assign bus.fill_ack        = ~rst && (state == IDLE) && bus.fill_req;
  assign bus.fill_beat_ready = (state == FILL);
  assign bus.arr_rd_en       = (state == RD);
  assign bus.arr_rd_index    = (state == RD) ? idx_q : '0;
  assign bus.arr_wr_en       = (state == WR);
  assign bus.arr_wr_index    = (state == WR) ? idx_q : '0;
  assign bus.arr_wr_data     = (state == WR) ? line_buf : '0;
  assign bus.wr_done         = (state == WR) && (op_q == OP_WRITE);
  assign bus.fill_done       = (state == WR) && (op_q == OP_FILL);
  assign bus.busy            = (state != IDLE);

endmodule

// File: tb/tb_cache_line_write_ctrl.sv
// Directed self-checking bench for cache_line_write_ctrl with a one-cycle-latency array model.
module tb_cache_line_write_ctrl;
  import cache_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_line_write_ctrl_if bus ();

  cache_line_write_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic [511:0] mem [64];
  int n_tests = 0;
  int n_fail  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) bus.arr_rd_data <= '0;
    else if (bus.arr_rd_en) bus.arr_rd_data <= mem[bus.arr_rd_index];
  end

  int           cyc = 0;
  int           n_wr_en = 0, n_wr_done = 0, n_fill_done = 0;
  int           wr_cyc_q[$];
  logic [511:0] wr_line_q[$];
  always @(negedge clk) begin
    cyc++;
    if (bus.arr_wr_en) begin
      n_wr_en++;
      wr_cyc_q.push_back(cyc);
      wr_line_q.push_back(bus.arr_wr_data);
    end
    if (bus.wr_done)   n_wr_done++;
    if (bus.fill_done) n_fill_done++;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input string tag, input logic [5:0] idx, input logic [3:0] off,
                          input logic [31:0] data, input logic [3:0] strb,
                          input logic [511:0] exp_line, output int waited);
    bus.wr_valid  = 1'b1;
    bus.wr_index  = idx;
    bus.wr_offset = off;
    bus.wr_data   = data;
`ifdef CACHE_WR_STRB_EN
    bus.wr_strb   = strb;
`else
    if (strb != 4'hF) $display("note: %s strobes ignored in this build", tag);
`endif
    waited = 0;
    #1;
    while (!bus.wr_ready && waited < 40) begin
      tick();
      waited++;
      #1;
    end
    chk({tag, "_ready"}, bus.wr_ready, 1);
    tick();
    bus.wr_valid = 1'b0;
    chk({tag, "_rd_en_t1"}, bus.arr_rd_en, 1);
    chk({tag, "_rd_idx"}, bus.arr_rd_index, idx);
    tick();
    chk({tag, "_t2_idle_ports"}, {bus.arr_rd_en, bus.arr_wr_en, bus.busy}, 3'b001);
    tick();
    chk({tag, "_wr_en_t3"}, {bus.arr_wr_en, bus.wr_done, bus.fill_done, bus.wr_ready}, 4'b1100);
    chk({tag, "_wr_idx"}, bus.arr_wr_index, idx);
    chk({tag, "_wr_data"}, bus.arr_wr_data, exp_line);
    tick();
    #1;
    chk({tag, "_t4_ready"}, {bus.arr_wr_en, bus.wr_done, bus.wr_ready}, 3'b001);
  endtask

  task automatic do_fill(input string tag, input logic [5:0] idx, input int stall_after,
                         input int stall_len, output int lat);
    logic [511:0] exp_line;
    int bad, w;
    bad = 0;
    bus.fill_req   = 1'b1;
    bus.fill_index = idx;
    #1;
    chk({tag, "_ack"}, {bus.fill_ack, bus.wr_ready}, 2'b10);
    tick();
    bus.fill_req = 1'b0;
    lat = 1;
    for (int k = 0; k < 16; k++) begin
      if (k == stall_after + 1 && stall_after >= 0) begin
        for (int s = 0; s < stall_len; s++) begin
          bus.fill_beat_valid = 1'b0;
          #1;
          if (!bus.fill_beat_ready || bus.arr_wr_en || bus.fill_ack) bad++;
          tick();
          lat++;
        end
      end
      bus.fill_beat_valid = 1'b1;
      bus.fill_beat_data  = 32'(k);
      #1;
      if (!bus.fill_beat_ready || bus.arr_wr_en || bus.wr_ready) bad++;
      tick();
      lat++;
    end
    bus.fill_beat_valid = 1'b0;
    chk({tag, "_beat_phase"}, 32'(bad), 0);
    w = 0;
    while (!bus.arr_wr_en && w < 30) begin
      tick();
      w++;
      lat++;
    end
    chk({tag, "_commit_wait"}, 32'(w), 0);
    exp_line = '0;
    for (int k = 0; k < 16; k++) exp_line[k*32 +: 32] = 32'(k);
    chk({tag, "_done"}, {bus.arr_wr_en, bus.fill_done, bus.wr_done}, 3'b110);
    chk({tag, "_wr_idx"}, bus.arr_wr_index, idx);
    chk({tag, "_wr_data"}, bus.arr_wr_data, exp_line);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    logic [511:0] exp_line;
    int waited, lat, base_wr, base_fd, base_wd, base_q;

    for (int i = 0; i < 64; i++) mem[i] = {16{32'h11111111}};
    mem[20] = '0;
    mem[20][4*32 +: 32] = 32'hAABBCCDD;

    bus.wr_valid = 0; bus.wr_index = 0; bus.wr_offset = 0; bus.wr_data = 0;
`ifdef CACHE_WR_STRB_EN
    bus.wr_strb = 0;
`endif
    bus.fill_req = 0; bus.fill_index = 0; bus.fill_beat_valid = 0; bus.fill_beat_data = 0;

    // Reset state
    @(negedge clk);
    #1;
    chk("reset_outputs", {bus.wr_ready, bus.fill_ack, bus.fill_beat_ready, bus.arr_rd_en,
                          bus.arr_wr_en, bus.wr_done, bus.fill_done, bus.busy}, 8'h00);
    chk("reset_wr_data", bus.arr_wr_data, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_ready", {bus.wr_ready, bus.busy}, 2'b10);

    // Single RMW write
    base_wd = n_wr_done;
    exp_line = {16{32'h11111111}};
    exp_line[3*32 +: 32] = 32'hDEADBEEF;
    do_write("w1", 6'd5, 4'd3, 32'hDEADBEEF, 4'hF, exp_line, waited);
    chk("w1_wait", 32'(waited), 0);
    chk("w1_done_count", 32'(n_wr_done - base_wd), 1);

    // Fill and write requested together: fill wins
    @(negedge clk);
    bus.wr_valid  = 1'b1;
    bus.wr_index  = 6'd9;
    bus.wr_offset = 4'd2;
    bus.wr_data   = 32'hCAFE0000;
    do_fill("f1", 6'd9, -1, 0, lat);
    chk("f1_latency", 32'(lat), 17);
    exp_line = {16{32'h11111111}};
    exp_line[2*32 +: 32] = 32'hCAFE0000;
    do_write("w2", 6'd9, 4'd2, 32'hCAFE0000, 4'hF, exp_line, waited);
    chk("w2_accept_next_idle", 32'(waited), 1);

    // Fill with a 3-cycle beat stall after beat 7
    @(negedge clk);
    do_fill("f2", 6'd33, 7, 3, lat);
    chk("f2_latency", 32'(lat), 20);
    tick();

    // Reset during FILL after 10 beats
    bus.fill_req   = 1'b1;
    bus.fill_index = 6'd12;
    tick();
    bus.fill_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.fill_beat_valid = 1'b1;
      bus.fill_beat_data  = 32'(k);
      tick();
    end
    base_wr = n_wr_en;
    base_fd = n_fill_done;
    rst = 1'b1;
    #1;
    chk("abort_outputs", {bus.wr_ready, bus.fill_ack, bus.fill_beat_ready, bus.arr_rd_en,
                          bus.arr_wr_en, bus.wr_done, bus.fill_done, bus.busy}, 8'h00);
    chk("abort_wr_data", bus.arr_wr_data, '0);
    tick();
    rst = 1'b0;
    bus.fill_beat_valid = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    chk("abort_no_commit", {32'(n_wr_en - base_wr), 32'(n_fill_done - base_fd)}, 64'd0);

    // Segment merge on a non-uniform line
    exp_line = mem[20];
`ifdef CACHE_WR_STRB_EN
    exp_line[4*32 +: 32] = 32'hAA22CC44;
    do_write("strb", 6'd20, 4'd4, 32'h11223344, 4'b0101, exp_line, waited);
`else
    exp_line[4*32 +: 32] = 32'h11223344;
    do_write("full", 6'd20, 4'd4, 32'h11223344, 4'hF, exp_line, waited);
`endif

    // Four back-to-back writes to index 63
    begin
      logic [3:0] offs [4];
      int acc, bad;
      logic fire;
      offs[0] = 4'd0; offs[1] = 4'd15; offs[2] = 4'd0; offs[3] = 4'd15;
      acc = 0;
      bad = 0;
      @(negedge clk);
      base_wr = n_wr_en;
      base_q  = wr_cyc_q.size();
      bus.wr_valid  = 1'b1;
      bus.wr_index  = 6'd63;
      bus.wr_offset = offs[0];
      bus.wr_data   = 32'hA0000000;
`ifdef CACHE_WR_STRB_EN
      bus.wr_strb   = 4'hF;
`endif
      for (int c = 0; c < 40; c++) begin
        #1;
        if (bus.busy && bus.wr_ready) bad++;
        fire = bus.wr_valid && bus.wr_ready;
        tick();
        if (fire) begin
          acc++;
          if (acc < 4) begin
            bus.wr_offset = offs[acc];
            bus.wr_data   = 32'hA0000000 + 32'(acc);
          end else begin
            bus.wr_valid = 1'b0;
          end
        end
        if (acc == 4 && !bus.busy) break;
      end
      chk("b2b_ready_low", 32'(bad), 0);
      chk("b2b_wr_count", 32'(n_wr_en - base_wr), 4);
      if (wr_cyc_q.size() >= base_q + 4) begin
        for (int i = 1; i < 4; i++)
          chk($sformatf("b2b_gap%0d", i),
              32'(wr_cyc_q[base_q+i] - wr_cyc_q[base_q+i-1]), 4);
        for (int i = 0; i < 4; i++) begin
          exp_line = {16{32'h11111111}};
          exp_line[int'(offs[i])*32 +: 32] = 32'hA0000000 + 32'(i);
          chk($sformatf("b2b_line%0d", i), wr_line_q[base_q+i], exp_line);
        end
      end else begin
        chk("b2b_queue", 32'(wr_cyc_q.size() - base_q), 4);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_line_write_ctrl.md
# cache_line_write_ctrl

Write-port scheduler for the cache data array. It serializes two requesters onto the single array read/write port:

- **CPU word writes**, done as a read-modify-write of one segment of a line.
- **Memory line fills**, assembled from NUM_SEGMENTS word beats and written as one line.

Fills take priority over CPU writes. Segment insertion uses the existing `replacer` word-merge datapath.

## Interface
Parameters:
- WORD_SIZE, 32, width of one segment/word
- BLOCK_SIZE, 512, line width
- NUM_SEGMENTS, 16, words per line
- NUM_SEGMENTS_LOG, 4, log2(NUM_SEGMENTS)
- INDEX_WIDTH, 6, data-array set index width

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_valid  in  1  CPU write request
- wr_ready  out  1  CPU write accepted when wr_valid & wr_ready
- wr_index  in  INDEX_WIDTH  target line
- wr_offset  in  NUM_SEGMENTS_LOG  target segment
- wr_data  in  WORD_SIZE  write word
- wr_strb  in  WORD_SIZE/8  byte strobes (present only with CACHE_WR_STRB_EN)
- fill_req  in  1  line-fill request, held high until fill_ack
- fill_index  in  INDEX_WIDTH  fill target line, sampled at fill_ack
- fill_ack  out  1  one-cycle pulse when the fill is accepted
- fill_beat_valid  in  1  fill beat present
- fill_beat_ready  out  1  beat accepted when fill_beat_valid & fill_beat_ready
- fill_beat_data  in  WORD_SIZE  beat word; beats arrive in segment order 0..NUM_SEGMENTS-1
- arr_rd_en  out  1  array read strobe; data returns on arr_rd_data the next cycle
- arr_rd_index  out  INDEX_WIDTH  read index
- arr_rd_data  in  BLOCK_SIZE  array read data
- arr_wr_en  out  1  array write strobe
- arr_wr_index  out  INDEX_WIDTH  write index
- arr_wr_data  out  BLOCK_SIZE  write line
- wr_done  out  1  pulse; CPU write committed
- fill_done  out  1  pulse; fill line committed
- busy  out  1  state != IDLE

## Operation
FSM states are IDLE, RD, MERGE, FILL, WR.

- **IDLE**
  - fill_req=1: assert fill_ack, capture fill_index, clear beat_cnt, go to FILL.
  - Otherwise, wr_valid & wr_ready: capture index, offset, data (and strobes), go to RD.
  - wr_ready = (state==IDLE) & ~fill_req, combinational. When both request in the same cycle, the fill wins and the write stalls.
- **RD**
  - arr_rd_en=1, arr_rd_index = captured index. Go to MERGE.
- **MERGE**
  - arr_rd_data is valid.
  - line_buf <= arr_rd_data with segment[offset] replaced by the merged word. Go to WR.
  - Without strobes, the merged word is wr_data.
  - With strobes, each byte comes from wr_data where its strobe is 1, else from the read word.
- **FILL**
  - fill_beat_ready=1. Each accepted beat writes segment[beat_cnt] of line_buf, then beat_cnt increments.
  - The beat accepted with beat_cnt==NUM_SEGMENTS-1 goes to WR; beat_cnt wraps to 0.
  - Stalled beats (valid low) hold state indefinitely.
- **WR**
  - arr_wr_en=1, arr_wr_index = captured index, arr_wr_data = line_buf.
  - Pulse wr_done or fill_done according to the operation type. Go to IDLE.

Other rules:
- Only one operation is in flight at a time. A write to a line being filled stalls until the fill commits.
- A fill request arriving mid-RMW waits. The RMW completes first, and the fill is acked in the following IDLE cycle.
- fill_beat_valid outside FILL is ignored (fill_beat_ready=0).

## Timing
- CPU write accepted at cycle T:
  - arr_rd_en at T+1
  - read data consumed at T+2
  - arr_wr_en and wr_done at T+3
  - wr_ready high again at T+4, so back-to-back throughput is 1 write per 4 cycles
- Fill acked at T, with beats on consecutive cycles T+1..T+16: arr_wr_en and fill_done at T+17.
- Reset values: all outputs 0, state=IDLE, beat_cnt=0, line_buf=0, captured registers=0.
- After reset, wr_ready follows its combinational rule immediately.
- Reset asserted mid-operation:
  - Immediate return to IDLE.
  - No array write is issued for the aborted operation and no done pulse occurs.
  - A partially collected fill is discarded.
- All array-port outputs are registered-state decodes, with no combinational path from request inputs to arr_* outputs.

## Configuration
- CACHE_WR_STRB_EN defined:
  - wr_strb port exists and is captured with the request.
  - MERGE does a byte-granular merge with the read word.
- Undefined:
  - No wr_strb port.
  - The whole segment is replaced by wr_data.
  - RD/MERGE timing is unchanged.

## Structure
- `cache_ctrl_pkg` holds:
  - the FSM state enum
  - the operation-type encoding (OP_WRITE, OP_FILL)
  - the default WORD_SIZE, BLOCK_SIZE, NUM_SEGMENTS and INDEX_WIDTH constants
- One sub-module: a `replacer` instance with enable tied high.
  - In MERGE it is fed arr_rd_data, the captured offset and the merged word.
  - In FILL it is fed line_buf, beat_cnt and fill_beat_data.
  - Its output loads line_buf.

## Test plan
- Reset, then write index 5 offset 3 data 0xDEADBEEF over array line all 0x11111111:
  - arr_rd_en at T+1.
  - arr_wr_en at T+3 with segment 3 = 0xDEADBEEF and all other segments 0x11111111.
  - wr_done pulses once.
- fill_req and wr_valid asserted in the same cycle:
  - fill_ack at once and wr_ready=0.
  - Beats 0x0..0xF fill index 9; arr_wr_data segment k = k and fill_done pulses.
  - The write is then accepted in the next IDLE cycle.
- Fill with fill_beat_valid dropped for 3 cycles after beat 7: beat_cnt holds, and commit is delayed by exactly 3 cycles.
- Reset asserted during FILL after 10 beats: no arr_wr_en and no fill_done; all outputs return to 0 the same cycle.
- Strobe merge (CACHE_WR_STRB_EN): read word 0xAABBCCDD, wr_data 0x11223344, wr_strb 4'b0101 gives a written segment of 0xAA22CC44.
- Four back-to-back writes, to offsets 0, 15, 0 and 15 of index 63: exactly 4 arr_wr_en spaced 4 cycles apart, and wr_ready low during each RMW.
